// File: rtl/operand_fetch_if.sv
// Bundles the decode, writeback, register-file and execute handshakes of the operand-fetch stage.
// The stage itself uses the slave view; the surrounding pipeline/testbench uses the master view.
interface operand_fetch_if #(
    parameter int REG_WIDTH  = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                  dec_valid;
    logic                  dec_ready;
    logic [ADDR_WIDTH-1:0] dec_rs1;
    logic [ADDR_WIDTH-1:0] dec_rs2;
    logic                  dec_use_rs1;
    logic                  dec_use_rs2;

    logic                  wb_valid;
    logic                  wb_ready;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic [REG_WIDTH-1:0]  wb_data;

    logic                  rf_read_en;
    logic                  rf_write_en;
    logic [ADDR_WIDTH-1:0] rf_addr;
    logic [REG_WIDTH-1:0]  rf_wr_data;
    logic                  rf_rd_data_val;
    logic [REG_WIDTH-1:0]  rf_rd_data;

    logic                  op_valid;
    logic                  op_ready;
    logic [REG_WIDTH-1:0]  op_rs1_data;
    logic [REG_WIDTH-1:0]  op_rs2_data;

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
        output dec_ready,
        input  wb_valid, wb_rd, wb_data,
        output wb_ready,
        output rf_read_en, rf_write_en, rf_addr, rf_wr_data,
        input  rf_rd_data_val, rf_rd_data,
        output op_valid, op_rs1_data, op_rs2_data,
        input  op_ready
    );

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
        input  dec_ready,
        output wb_valid, wb_rd, wb_data,
        input  wb_ready,
        input  rf_read_en, rf_write_en, rf_addr, rf_wr_data,
        output rf_rd_data_val, rf_rd_data,
        input  op_valid, op_rs1_data, op_rs2_data,
        output op_ready
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand-fetch stage: sequences up to two reads through the shared register-file port,
// gives writeback priority on that port, and bypasses writeback data into held operands.
module operand_fetch #(
    parameter int REG_WIDTH  = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    operand_fetch_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE1,
        S_WAIT1,
        S_ISSUE2,
        S_WAIT2,
        S_OUT
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rs1_q, rs1_d;
    logic [ADDR_WIDTH-1:0] rs2_q, rs2_d;
    logic                  need1_q, need1_d;
    logic                  need2_q, need2_d;
    logic [REG_WIDTH-1:0]  op1_q, op1_d;
    logic [REG_WIDTH-1:0]  op2_q, op2_d;
    logic                  wr_last_q, wr_last_d;

    logic                  wb_fire;
    logic                  wr_en;
    logic                  stall;
    logic                  rd_en;
    logic                  new_need1;
    logic                  new_need2;
    logic                  byp1;
    logic                  byp2;

    // Writeback is accepted whenever out of reset; index 0 writes are swallowed silently.
    always_comb begin
        wb_fire   = bus.wb_valid & rst_n;
        wr_en     = wb_fire & (bus.wb_rd != '0);
        stall     = wr_en | wr_last_q;
        new_need1 = bus.dec_use_rs1 & (bus.dec_rs1 != '0);
        new_need2 = bus.dec_use_rs2 & (bus.dec_rs2 != '0);
        byp1      = wr_en & (state_q != S_IDLE) & need1_q & (bus.wb_rd == rs1_q);
        byp2      = wr_en & (state_q != S_IDLE) & need2_q & (bus.wb_rd == rs2_q);
    end

    always_comb begin
        state_d   = state_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        need1_d   = need1_q;
        need2_d   = need2_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        wr_last_d = wr_en;
        rd_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.dec_valid) begin
                    rs1_d   = bus.dec_rs1;
                    rs2_d   = bus.dec_rs2;
                    need1_d = new_need1;
                    need2_d = new_need2;
                    op1_d   = '0;
                    op2_d   = '0;
                    if (new_need1)      state_d = S_ISSUE1;
                    else if (new_need2) state_d = S_ISSUE2;
                    else                state_d = S_OUT;
                end
            end
            S_ISSUE1: begin
                rd_en = ~stall;
                if (!stall) state_d = S_WAIT1;
            end
            S_WAIT1: begin
                if (bus.rf_rd_data_val) begin
                    op1_d   = bus.rf_rd_data;
                    state_d = need2_q ? S_ISSUE2 : S_OUT;
                end
            end
            S_ISSUE2: begin
                rd_en = ~stall;
                if (!stall) state_d = S_WAIT2;
            end
            S_WAIT2: begin
                if (bus.rf_rd_data_val) begin
                    op2_d   = bus.rf_rd_data;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.op_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Applied after the read capture so fresh writeback data beats a stale read in the same cycle.
        if (byp1) op1_d = bus.wb_data;
        if (byp2) op2_d = bus.wb_data;

        rd_en = rd_en & rst_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rs1_q     <= '0;
            rs2_q     <= '0;
            need1_q   <= 1'b0;
            need2_q   <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            wr_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            need1_q   <= need1_d;
            need2_q   <= need2_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            wr_last_q <= wr_last_d;
        end
    end

    assign bus.dec_ready   = (state_q == S_IDLE);
    assign bus.wb_ready    = rst_n;
    assign bus.rf_read_en  = rd_en;
    assign bus.rf_write_en = wr_en;
    assign bus.rf_addr     = rd_en ? ((state_q == S_ISSUE1) ? rs1_q : rs2_q) :
                             wr_en ? bus.wb_rd : '0;
    assign bus.rf_wr_data  = wr_en ? bus.wb_data : '0;
    assign bus.op_valid    = (state_q == S_OUT);
    assign bus.op_rs1_data = op1_q;
    assign bus.op_rs2_data = op2_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: register-file model, scoreboard of expected operand
// pairs, and one task per scenario with cycle-exact checks.
module tb_operand_fetch;
    localparam int RW = 32;
    localparam int AW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    operand_fetch_if #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) bus ();
    operand_fetch #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    logic [2*RW-1:0] exp_q[$];
    logic [RW-1:0]   ref_rf [16];

    // Register-file model: one-cycle read latency, optional injected late data.
    logic [RW-1:0] mem [16];
    logic          mdl_val  = 1'b0;
    logic [RW-1:0] mdl_data = '0;
    logic          inj_val  = 1'b0;
    logic [RW-1:0] inj_data = '0;
    always @(posedge clk) begin
        if (bus.rf_write_en) mem[bus.rf_addr] <= bus.rf_wr_data;
        mdl_val  <= bus.rf_read_en;
        mdl_data <= mem[bus.rf_addr];
    end
    assign bus.rf_rd_data_val = mdl_val | inj_val;
    assign bus.rf_rd_data     = inj_val ? inj_data : mdl_data;

    // Scoreboard: every operand handshake must match the oldest expected pair.
    always @(negedge clk) begin
        if (rst_n && bus.op_valid && bus.op_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL op_unexpected: got %h_%h expected no output", bus.op_rs1_data, bus.op_rs2_data);
            end else begin
                logic [2*RW-1:0] e;
                e = exp_q.pop_front();
                if ({bus.op_rs1_data, bus.op_rs2_data} !== e)
                    $display("FAIL op_data: got %h_%h expected %h_%h", bus.op_rs1_data, bus.op_rs2_data, e[2*RW-1:RW], e[RW-1:0]);
                else n_pass++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.dec_valid   = 1'b0;
        bus.dec_rs1     = '0;
        bus.dec_rs2     = '0;
        bus.dec_use_rs1 = 1'b0;
        bus.dec_use_rs2 = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = '0;
        bus.wb_data     = '0;
        bus.op_ready    = 1'b1;
    endtask

    task automatic request(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic u1, input logic u2);
        bus.dec_valid   = 1'b1;
        bus.dec_rs1     = rs1;
        bus.dec_rs2     = rs2;
        bus.dec_use_rs1 = u1;
        bus.dec_use_rs2 = u2;
    endtask

    task automatic wb_write(input logic [AW-1:0] rd, input logic [RW-1:0] d);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd;
        bus.wb_data  = d;
        step();
        bus.wb_valid = 1'b0;
        ref_rf[rd]   = d;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n        = 1'b0;
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 4'd5;
        bus.wb_data  = 32'hDEAD_BEEF;
        step();
        step();
        @(negedge clk);
        n_checks++; if (bus.wb_ready !== 1'b0) $display("FAIL reset_wb_ready: got %b expected 0", bus.wb_ready); else n_pass++;
        n_checks++; if ({bus.rf_read_en, bus.rf_write_en, bus.op_valid} !== 3'b000)
            $display("FAIL reset_strobes: got %b expected 000", {bus.rf_read_en, bus.rf_write_en, bus.op_valid}); else n_pass++;
        n_checks++; if ({bus.op_rs1_data, bus.op_rs2_data} !== 64'd0)
            $display("FAIL reset_operands: got %h_%h expected 0_0", bus.op_rs1_data, bus.op_rs2_data); else n_pass++;
        step();
        bus.wb_valid = 1'b0;
        rst_n        = 1'b1;
        @(negedge clk);
        n_checks++; if ({bus.wb_ready, bus.dec_ready} !== 2'b11)
            $display("FAIL after_reset_ready: got %b expected 11", {bus.wb_ready, bus.dec_ready}); else n_pass++;
    endtask

    task automatic preload();
        step();
        wb_write(4'd1, 32'hAAAA_0001);
        wb_write(4'd2, 32'h5555_0002);
        wb_write(4'd3, 32'h3333_0003);
        wb_write(4'd4, 32'h4444_0004);
        step();
    endtask

    task automatic test_two_reads();
        step();
        request(4'd1, 4'd2, 1'b1, 1'b1);
        exp_q.push_back({32'hAAAA_0001, 32'h5555_0002});
        for (int k = 1; k <= 6; k++) begin
            logic [AW+1:0] exp_v;
            step();
            if (k == 1) bus.dec_valid = 1'b0;
            @(negedge clk);
            exp_v = {(k == 1 || k == 3), ((k == 1) ? 4'd1 : (k == 3) ? 4'd2 : 4'd0), (k == 5)};
            n_checks++; if ({bus.rf_read_en, bus.rf_addr, bus.op_valid} !== exp_v)
                $display("FAIL two_reads_t%0d: got %b expected %b", k, {bus.rf_read_en, bus.rf_addr, bus.op_valid}, exp_v); else n_pass++;
        end
    endtask

    task automatic test_x0_operand();
        step();
        request(4'd0, 4'd3, 1'b1, 1'b1);
        exp_q.push_back({32'd0, ref_rf[3]});
        for (int k = 1; k <= 4; k++) begin
            logic [AW+1:0] exp_v;
            step();
            if (k == 1) bus.dec_valid = 1'b0;
            @(negedge clk);
            exp_v = {(k == 1), ((k == 1) ? 4'd3 : 4'd0), (k == 3)};
            n_checks++; if ({bus.rf_read_en, bus.rf_addr, bus.op_valid} !== exp_v)
                $display("FAIL x0_t%0d: got %b expected %b", k, {bus.rf_read_en, bus.rf_addr, bus.op_valid}, exp_v); else n_pass++;
        end
    endtask

    task automatic test_wb_stall();
        step();
        request(4'd1, 4'd7, 1'b1, 1'b0);
        exp_q.push_back({ref_rf[1], 32'd0});
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 4'd4;
        bus.wb_data  = 32'h4444_0100;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k == 1) bus.dec_valid = 1'b0;
            bus.wb_data = 32'h4444_0100 + 32'(k);
            @(negedge clk);
            n_checks++; if ({bus.rf_read_en, bus.rf_write_en, bus.wb_ready, bus.rf_addr} !== {3'b011, 4'd4})
                $display("FAIL wb_stall_t%0d: got %b expected 0110100", k, {bus.rf_read_en, bus.rf_write_en, bus.wb_ready, bus.rf_addr}); else n_pass++;
        end
        ref_rf[4] = 32'h4444_0103;
        step();
        bus.wb_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.rf_read_en !== 1'b0) $display("FAIL wb_turnaround: got %b expected 0", bus.rf_read_en); else n_pass++;
        step();
        @(negedge clk);
        n_checks++; if ({bus.rf_read_en, bus.rf_addr} !== {1'b1, 4'd1})
            $display("FAIL wb_read_resume: got %b expected 10001", {bus.rf_read_en, bus.rf_addr}); else n_pass++;
        step();
        step();
        @(negedge clk);
        n_checks++; if (bus.op_valid !== 1'b1) $display("FAIL wb_stall_out: got %b expected 1", bus.op_valid); else n_pass++;
    endtask

    task automatic test_wb_x0();
        step();
        request(4'd2, 4'd0, 1'b1, 1'b0);
        exp_q.push_back({ref_rf[2], 32'd0});
        step();
        bus.dec_valid = 1'b0;
        bus.wb_valid  = 1'b1;
        bus.wb_rd     = 4'd0;
        bus.wb_data   = 32'hFFFF_FFFF;
        @(negedge clk);
        n_checks++; if ({bus.rf_read_en, bus.rf_write_en, bus.wb_ready, bus.rf_addr} !== {3'b101, 4'd2})
            $display("FAIL wb_x0_drop: got %b expected 1010010", {bus.rf_read_en, bus.rf_write_en, bus.wb_ready, bus.rf_addr}); else n_pass++;
        step();
        bus.wb_valid = 1'b0;
        step();
        @(negedge clk);
        n_checks++; if (bus.op_valid !== 1'b1) $display("FAIL wb_x0_out: got %b expected 1", bus.op_valid); else n_pass++;
    endtask

    task automatic test_bypass_wait2();
        step();
        request(4'd1, 4'd2, 1'b1, 1'b1);
        exp_q.push_back({ref_rf[1], 32'h0000_1234});
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) bus.dec_valid = 1'b0;
            if (k == 4) begin
                bus.wb_valid = 1'b1;
                bus.wb_rd    = 4'd2;
                bus.wb_data  = 32'h0000_1234;
            end
            if (k == 5) bus.wb_valid = 1'b0;
            @(negedge clk);
            if (k == 4) begin
                n_checks++; if ({bus.rf_write_en, bus.rf_read_en, bus.rf_rd_data_val} !== 3'b101)
                    $display("FAIL bypass_wait2_port: got %b expected 101", {bus.rf_write_en, bus.rf_read_en, bus.rf_rd_data_val}); else n_pass++;
            end
            if (k == 5) begin
                n_checks++; if ({bus.op_valid, bus.op_rs2_data} !== {1'b1, 32'h0000_1234})
                    $display("FAIL bypass_wait2_op: got %b/%h expected 1/00001234", bus.op_valid, bus.op_rs2_data); else n_pass++;
            end
        end
        ref_rf[2] = 32'h0000_1234;
    endtask

    task automatic test_out_hold();
        logic [RW-1:0] old1;
        old1 = ref_rf[1];
        step();
        bus.op_ready = 1'b0;
        request(4'd1, 4'd3, 1'b1, 1'b1);
        exp_q.push_back({32'h0000_BEEF, ref_rf[3]});
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k == 1) bus.dec_valid = 1'b0;
            if (k == 5) request(4'd5, 4'd6, 1'b1, 1'b1);
            if (k == 6) begin
                bus.wb_valid = 1'b1;
                bus.wb_rd    = 4'd1;
                bus.wb_data  = 32'h0000_BEEF;
            end
            if (k == 7) bus.wb_valid = 1'b0;
            if (k == 10) begin
                bus.op_ready  = 1'b1;
                bus.dec_valid = 1'b0;
            end
            @(negedge clk);
            if (k >= 5 && k <= 9) begin
                n_checks++; if ({bus.op_valid, bus.dec_ready} !== 2'b10)
                    $display("FAIL out_hold_t%0d: got %b expected 10", k, {bus.op_valid, bus.dec_ready}); else n_pass++;
            end
            if (k == 5) begin
                n_checks++; if (bus.op_rs1_data !== old1) $display("FAIL out_hold_old: got %h expected %h", bus.op_rs1_data, old1); else n_pass++;
            end
            if (k == 7) begin
                n_checks++; if (bus.op_rs1_data !== 32'h0000_BEEF) $display("FAIL out_hold_bypass: got %h expected 0000beef", bus.op_rs1_data); else n_pass++;
            end
            if (k == 11) begin
                n_checks++; if ({bus.op_valid, bus.dec_ready} !== 2'b01)
                    $display("FAIL out_release: got %b expected 01", {bus.op_valid, bus.dec_ready}); else n_pass++;
            end
        end
        ref_rf[1] = 32'h0000_BEEF;
    endtask

    task automatic test_reset_mid();
        step();
        request(4'd1, 4'd2, 1'b1, 1'b1);
        step();
        bus.dec_valid = 1'b0;
        step();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.wb_ready !== 1'b0) $display("FAIL reset_mid_wb_ready: got %b expected 0", bus.wb_ready); else n_pass++;
        step();
        rst_n    = 1'b1;
        inj_val  = 1'b1;
        inj_data = 32'hFFFF_FFFF;
        @(negedge clk);
        n_checks++; if ({bus.op_valid, bus.dec_ready, bus.op_rs1_data, bus.op_rs2_data} !== {2'b01, 64'd0})
            $display("FAIL reset_mid_idle: got %b %h_%h expected 01 0_0", {bus.op_valid, bus.dec_ready}, bus.op_rs1_data, bus.op_rs2_data); else n_pass++;
        step();
        inj_val = 1'b0;
        @(negedge clk);
        n_checks++; if ({bus.op_valid, bus.op_rs1_data, bus.op_rs2_data} !== 65'd0)
            $display("FAIL reset_mid_late_val: got %b %h_%h expected 0 0_0", bus.op_valid, bus.op_rs1_data, bus.op_rs2_data); else n_pass++;
    endtask

    task automatic test_no_operands();
        step();
        request(4'd5, 4'd6, 1'b0, 1'b0);
        exp_q.push_back(64'd0);
        step();
        bus.dec_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({bus.op_valid, bus.rf_read_en} !== 2'b10)
            $display("FAIL no_ops_out: got %b expected 10", {bus.op_valid, bus.rf_read_en}); else n_pass++;
        step();
        @(negedge clk);
        n_checks++; if (bus.op_valid !== 1'b0) $display("FAIL no_ops_done: got %b expected 0", bus.op_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        step();
        request(4'd3, 4'd4, 1'b1, 1'b1);
        exp_q.push_back({ref_rf[3], ref_rf[4]});
        exp_q.push_back({ref_rf[3], ref_rf[4]});
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 7) bus.dec_valid = 1'b0;
            @(negedge clk);
            if (k == 5 || k == 11 || k == 6 || k == 12) begin
                n_checks++; if ({bus.op_valid, bus.dec_ready} !== ((k == 5 || k == 11) ? 2'b10 : 2'b01))
                    $display("FAIL back_to_back_t%0d: got %b expected %b", k, {bus.op_valid, bus.dec_ready}, ((k == 5 || k == 11) ? 2'b10 : 2'b01)); else n_pass++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        preload();
        test_two_reads();
        test_x0_operand();
        test_wb_stall();
        test_wb_x0();
        test_bypass_wait2();
        test_out_hold();
        test_reset_mid();
        test_no_operands();
        test_back_to_back();
        step();
        step();
        n_checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
